// File: rtl/bf_adder_if.sv
// Operand/result bundle for the bfloat16 adder.
interface bf_adder_if;
  logic        in_valid;
  logic [15:0] num1;
  logic [15:0] num2;
  logic        out_valid;
  logic [15:0] sum;

  modport master (output in_valid, num1, num2, input out_valid, sum);
  modport slave  (input in_valid, num1, num2, output out_valid, sum);
endinterface

// File: rtl/bf_adder.sv
// Two-stage pipelined bfloat16 adder (align / add-normalize-round).
// Define BF_ADDER_RNE_EN for round-to-nearest-even; default build truncates toward zero.
module bf_adder (
  input  logic             clk,
  input  logic             rst,
  bf_adder_if.slave        bus
);

  localparam int unsigned EXP_W  = 8;
  localparam int unsigned FRAC_W = 7;
  localparam int unsigned MANT_W = 11;
  localparam logic [EXP_W-1:0] EXP_MAX = 8'hFF;
  localparam logic [15:0] QNAN = 16'h7FC0;

`ifdef BF_ADDER_RNE_EN
  localparam bit RNE_ON = 1'b1;
`else
  localparam bit RNE_ON = 1'b0;
`endif

  // stage 1 combinational
  logic [15:0]       a_c, b_c, big_c, sml_c;
  logic              a_big_c;
  logic [EXP_W-1:0]  d_c;
  logic [MANT_W-1:0] ma_c, ext_c, mb_c;
  logic [2*MANT_W-1:0] wide_c;
  logic              spec_c;
  logic [15:0]       spec_val_c;
  logic              a_nan_c, b_nan_c, a_inf_c, b_inf_c, a_zero_c, b_zero_c;

  // stage 1 registers
  logic              v1, spec1, sign1, sub1;
  logic [15:0]       spec_val1;
  logic [EXP_W-1:0]  exp1;
  logic [MANT_W-1:0] ma1, mb1;

  // stage 2 combinational
  logic [MANT_W:0]   raw_c;
  logic [3:0]        lz_c;
  logic [MANT_W-1:0] norm_c;
  logic signed [9:0] e_base_c, e2_c, e3_c;
  logic              round_up_c;
  logic [8:0]        mant9_c;
  logic [FRAC_W-1:0] frac_c;
  logic [15:0]       res_c;

  // Unpack, classify specials, order by magnitude and align the smaller operand
  always_comb begin
    a_c        = bus.in_valid ? bus.num1 : 16'h0000;
    b_c        = bus.in_valid ? bus.num2 : 16'h0000;
    a_nan_c    = (a_c[14:7] == EXP_MAX) && (a_c[6:0] != '0);
    b_nan_c    = (b_c[14:7] == EXP_MAX) && (b_c[6:0] != '0);
    a_inf_c    = (a_c[14:7] == EXP_MAX) && (a_c[6:0] == '0);
    b_inf_c    = (b_c[14:7] == EXP_MAX) && (b_c[6:0] == '0);
    a_zero_c   = (a_c[14:7] == '0);
    b_zero_c   = (b_c[14:7] == '0);
    spec_c     = 1'b1;
    spec_val_c = 16'h0000;
    if (a_nan_c || b_nan_c)      spec_val_c = QNAN;
    else if (a_inf_c && b_inf_c) spec_val_c = (a_c[15] != b_c[15]) ? QNAN : a_c;
    else if (a_inf_c)            spec_val_c = a_c;
    else if (b_inf_c)            spec_val_c = b_c;
    else if (a_zero_c && b_zero_c) spec_val_c = {a_c[15] & b_c[15], 15'h0000};
    else if (a_zero_c)           spec_val_c = b_c;
    else if (b_zero_c)           spec_val_c = a_c;
    else                         spec_c = 1'b0;

    a_big_c = a_c[14:0] >= b_c[14:0];
    big_c   = a_big_c ? a_c : b_c;
    sml_c   = a_big_c ? b_c : a_c;
    d_c     = big_c[14:7] - sml_c[14:7];
    ma_c    = {(big_c[14:7] != '0), big_c[6:0], 3'b000};
    ext_c   = {(sml_c[14:7] != '0), sml_c[6:0], 3'b000};
    wide_c  = {ext_c, 11'd0} >> d_c;
    // Bits shifted past the extension collapse into the sticky position
    if (d_c >= 8'd11) mb_c = 11'd1;
    else              mb_c = {wide_c[21:12], wide_c[11] | (|wide_c[10:0])};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v1        <= 1'b0;
      spec1     <= 1'b0;
      spec_val1 <= '0;
      sign1     <= 1'b0;
      sub1      <= 1'b0;
      exp1      <= '0;
      ma1       <= '0;
      mb1       <= '0;
    end else begin
      v1        <= bus.in_valid;
      spec1     <= spec_c;
      spec_val1 <= spec_val_c;
      sign1     <= big_c[15];
      sub1      <= a_c[15] ^ b_c[15];
      exp1      <= big_c[14:7];
      ma1       <= ma_c;
      mb1       <= mb_c;
    end
  end

  // Add/subtract, normalize, round, then range-check the exponent
  always_comb begin
    lz_c     = '0;
    e_base_c = $signed({2'b00, exp1});
    raw_c    = sub1 ? ({1'b0, ma1} - {1'b0, mb1}) : ({1'b0, ma1} + {1'b0, mb1});
    for (int i = 0; i < MANT_W; i++) begin
      if (raw_c[i]) lz_c = 4'(MANT_W - 1 - i);
    end
    if (raw_c[MANT_W]) begin
      norm_c = {raw_c[11:2], raw_c[1] | raw_c[0]};
      e2_c   = e_base_c + 10'sd1;
    end else begin
      norm_c = raw_c[10:0] << lz_c;
      e2_c   = e_base_c - $signed({6'd0, lz_c});
    end
    round_up_c = RNE_ON & norm_c[2] & (norm_c[1] | norm_c[0] | norm_c[3]);
    mant9_c    = {1'b0, norm_c[10:3]} + {8'd0, round_up_c};
    if (mant9_c[8]) begin
      frac_c = mant9_c[7:1];
      e3_c   = e2_c + 10'sd1;
    end else begin
      frac_c = mant9_c[6:0];
      e3_c   = e2_c;
    end
    if (spec1)                 res_c = spec_val1;
    else if (raw_c == '0)      res_c = 16'h0000;
    else if (e3_c >= 10'sd255) res_c = {sign1, EXP_MAX, 7'h00};
    else if (e3_c <= 10'sd0)   res_c = {sign1, 15'h0000};
    else                       res_c = {sign1, e3_c[7:0], frac_c};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.out_valid <= 1'b0;
      bus.sum       <= 16'h0000;
    end else begin
      bus.out_valid <= v1;
      if (v1) bus.sum <= res_c;
    end
  end

endmodule

// File: tb/tb_bf_adder.sv
// Self-checking bench for bf_adder: directed cases plus random operands vs a real-valued model.
module tb_bf_adder;

`ifdef BF_ADDER_RNE_EN
  localparam bit RNE = 1'b1;
`else
  localparam bit RNE = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  int   tests = 0;
  int   fails = 0;

  bf_adder_if bus ();
  bf_adder dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  typedef struct packed {
    logic        v;
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] e;
  } exp_t;

  exp_t        q[$];
  logic [15:0] last_sum;

  function automatic real pow2(int k);
    real r = 1.0;
    if (k >= 0) for (int i = 0; i < k; i++) r = r * 2.0;
    else        for (int i = 0; i < -k; i++) r = r / 2.0;
    return r;
  endfunction

  function automatic real to_real(logic [15:0] x);
    real mag;
    if (x[14:7] == 8'd0) return 0.0;
    mag = real'(128 + int'(x[6:0])) * pow2(int'(x[14:7]) - 134);
    return x[15] ? -mag : mag;
  endfunction

  // Reference: exact sum in real arithmetic, then round to 8 significant bits
  function automatic logic [15:0] ref_add(logic [15:0] a, logic [15:0] b);
    logic a_nan, b_nan, a_inf, b_inf, s;
    real  v, m, sc, fr;
    int   e, ip, be;
    a_nan = (a[14:7] == 8'hFF) && (a[6:0] != 0);
    b_nan = (b[14:7] == 8'hFF) && (b[6:0] != 0);
    a_inf = (a[14:7] == 8'hFF) && (a[6:0] == 0);
    b_inf = (b[14:7] == 8'hFF) && (b[6:0] == 0);
    if (a_nan || b_nan) return 16'h7FC0;
    if (a_inf && b_inf) return (a[15] != b[15]) ? 16'h7FC0 : a;
    if (a_inf) return a;
    if (b_inf) return b;
    if (a[14:7] == 0 && b[14:7] == 0) return {a[15] & b[15], 15'h0};
    if (a[14:7] == 0) return b;
    if (b[14:7] == 0) return a;
    v = to_real(a) + to_real(b);
    if (v == 0.0) return 16'h0000;
    s = (v < 0.0);
    m = s ? -v : v;
    e = 0;
    while (m >= 2.0) begin m = m / 2.0; e++; end
    while (m < 1.0)  begin m = m * 2.0; e--; end
    sc = m * 128.0;
    ip = $rtoi(sc);
    fr = sc - real'(ip);
    if (RNE && (fr > 0.5 || (fr == 0.5 && ip[0]))) ip++;
    if (ip == 256) begin ip = 128; e++; end
    be = e + 127;
    if (be >= 255) return {s, 8'hFF, 7'h00};
    if (be <= 0)   return {s, 15'h0};
    return {s, 8'(be), 7'(ip)};
  endfunction

  function automatic logic [15:0] rnd_normal();
    return {1'($urandom), 8'($urandom_range(254, 1)), 7'($urandom)};
  endfunction

  function automatic logic [15:0] rnd_near(logic [15:0] a);
    int e;
    e = int'(a[14:7]) + int'($urandom_range(40, 0)) - 20;
    if (e < 1)   e = 1;
    if (e > 254) e = 254;
    return {1'($urandom), 8'(e), 7'($urandom)};
  endfunction

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s: got %h expected %h", tag, obs, expv);
    end
  endtask

  task automatic reset_model();
    q.delete();
    q.push_back('0);
    last_sum = 16'h0000;
  endtask

  // Drive one cycle of input, then check the output due this cycle
  task automatic cycle(input logic v, input logic [15:0] a, input logic [15:0] b,
                       input logic [15:0] expv);
    exp_t head;
    bus.in_valid = v;
    bus.num1     = v ? a : 16'h0000;
    bus.num2     = v ? b : 16'h0000;
    q.push_back({v, a, b, expv});
    @(negedge clk);
    head = q.pop_front();
    if (head.v) last_sum = head.e;
    chk($sformatf("out_valid %h+%h", head.a, head.b), {15'd0, bus.out_valid}, {15'd0, head.v});
    chk($sformatf("sum %h+%h v=%0b", head.a, head.b, head.v), bus.sum, last_sum);
  endtask

  initial begin
    logic [15:0] ra, rb;
    rst = 1'b1;
    bus.in_valid = 1'b0;
    bus.num1 = 16'h0000;
    bus.num2 = 16'h0000;
    repeat (2) @(negedge clk);
    chk("reset out_valid", {15'd0, bus.out_valid}, 16'h0000);
    chk("reset sum", bus.sum, 16'h0000);
    rst = 1'b0;
    reset_model();

    cycle(1'b1, 16'h3F80, 16'h3F80, 16'h4000);
    cycle(1'b0, 16'h0000, 16'h0000, 16'h0000);
    cycle(1'b0, 16'h0000, 16'h0000, 16'h0000);
    cycle(1'b1, 16'h3F80, 16'hBF80, 16'h0000);
    cycle(1'b1, 16'h8000, 16'h8000, 16'h8000);
    cycle(1'b1, 16'h0000, 16'hC040, 16'hC040);
    cycle(1'b1, 16'h3F80, 16'h3BC0, RNE ? 16'h3F81 : 16'h3F80);
    cycle(1'b1, 16'h3F80, 16'h3B80, 16'h3F80);
    cycle(1'b1, 16'h3F80, 16'h8080, RNE ? 16'h3F80 : 16'h3F7F);
    cycle(1'b1, 16'h7F7F, 16'h7F7F, 16'h7F80);
    cycle(1'b1, 16'hFF7F, 16'hFF7F, 16'hFF80);
    cycle(1'b1, 16'h7F80, 16'hFF80, 16'h7FC0);
    cycle(1'b1, 16'h7F80, 16'hC2C8, 16'h7F80);
    cycle(1'b1, 16'h7FC1, 16'h3F80, 16'h7FC0);
    cycle(1'b1, 16'h8000, 16'h0000, 16'h0000);
    cycle(1'b1, 16'h0001, 16'h4000, 16'h4000);
    cycle(1'b0, 16'h0000, 16'h0000, 16'h0000);
    cycle(1'b1, 16'h4040, 16'h3F80, 16'h4080);
    cycle(1'b1, 16'h40A0, 16'hC0A0, 16'h0000);
    cycle(1'b1, 16'h4120, 16'h0080, 16'h4120);
    cycle(1'b0, 16'h0000, 16'h0000, 16'h0000);
    cycle(1'b0, 16'h0000, 16'h0000, 16'h0000);

    // Reset with one op at the output and another in the first stage
    cycle(1'b1, 16'h4040, 16'h3F80, 16'h4080);
    bus.in_valid = 1'b1;
    bus.num1 = 16'h3F80;
    bus.num2 = 16'h3F80;
    @(posedge clk);
    #2;
    chk("pre-reset sum", bus.sum, 16'h4080);
    chk("pre-reset out_valid", {15'd0, bus.out_valid}, 16'h0001);
    rst = 1'b1;
    bus.in_valid = 1'b0;
    bus.num1 = 16'h0000;
    bus.num2 = 16'h0000;
    #1;
    chk("mid reset sum", bus.sum, 16'h0000);
    chk("mid reset out_valid", {15'd0, bus.out_valid}, 16'h0000);
    @(negedge clk);
    rst = 1'b0;
    reset_model();
    repeat (3) cycle(1'b0, 16'h0000, 16'h0000, 16'h0000);

    for (int n = 0; n < 400; n++) begin
      ra = rnd_normal();
      case ($urandom_range(15, 0))
        0:       rb = ra ^ 16'h8000;
        1:       rb = ra;
        2: begin
          case ($urandom_range(5, 0))
            0: rb = 16'h0000;
            1: rb = 16'h8000;
            2: rb = 16'h7F80;
            3: rb = 16'hFF80;
            4: rb = 16'h7FC0;
            default: rb = 16'h0041;
          endcase
        end
        default: rb = rnd_near(ra);
      endcase
      if ($urandom_range(3, 0) == 0) cycle(1'b0, 16'h0000, 16'h0000, 16'h0000);
      else                           cycle(1'b1, ra, rb, ref_add(ra, rb));
    end
    repeat (2) cycle(1'b0, 16'h0000, 16'h0000, 16'h0000);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
